// File: rtl/dpram_pkg.sv
// Shared constants and types for the dual-port RAM stream reader.
package dpram_pkg;

  localparam int DEF_ADDRESS_DEPTH = 16;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_SIZE  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO holding RAM words (with a last tag) until the consumer takes them.
module stream_skid_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);

  logic [DATA_WIDTH:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (!push_i && pop_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last_o = mem_q[rd_ptr_q][DATA_WIDTH];

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst read master for the dual-port RAM read port, presenting words as a valid/ready stream.
// state | meaning
// IDLE  | waiting for start; first read of a burst is issued directly on start
// ISSUE | issuing reads while the buffer has room for the returning data
// DRAIN | all reads issued; waiting for the last word to be accepted
module dpram_stream_reader
  import dpram_pkg::*;
#(
  parameter int ADDRESS_DEPTH = DEF_ADDRESS_DEPTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_SIZE  = DEF_ADDRESS_SIZE,
  parameter int BUF_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic [ADDRESS_SIZE:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_re,
  output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int LEN_W = ADDRESS_SIZE + 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  rd_state_e             state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d, ram_rd_addr_q, ram_rd_addr_d, issue_addr;
  logic [LEN_W-1:0]      remaining_q, remaining_d, issue_rem, len_eff;
  logic                  ram_re_q, ram_re_d, re_last_q, re_last_d;
  logic                  pending_q, pending_last_q, issue;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      occupancy;
  logic                  head_last, fire;

  assign len_eff   = (length > LEN_W'(ADDRESS_DEPTH)) ? LEN_W'(ADDRESS_DEPTH) : length;
  // Words already buffered plus reads whose data is still on its way back.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(ram_re_q) + OCC_W'(pending_q);
  assign out_valid = (fifo_count != '0);
  assign out_last  = out_valid && head_last;
  assign fire      = out_valid && out_ready;
  assign done      = (state_q == DRAIN) && fire && head_last;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    ram_re_d      = 1'b0;
    ram_rd_addr_d = ram_rd_addr_q;
    re_last_d     = 1'b0;
    issue         = 1'b0;
    issue_addr    = addr_q;
    issue_rem     = remaining_q;
    case (state_q)
      IDLE: begin
        // Issuing on start itself keeps start-to-valid latency at three cycles.
        if (start && (len_eff != '0)) begin
          issue      = 1'b1;
          issue_addr = base_addr;
          issue_rem  = len_eff;
          state_d    = ISSUE;
        end
      end
      ISSUE:   issue = (remaining_q != '0) && (occupancy < OCC_W'(BUF_DEPTH));
      DRAIN:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      ram_re_d      = 1'b1;
      ram_rd_addr_d = issue_addr;
      addr_d        = issue_addr + ADDRESS_SIZE'(1);
      remaining_d   = issue_rem - LEN_W'(1);
      re_last_d     = (issue_rem == LEN_W'(1));
      if (issue_rem == LEN_W'(1)) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      ram_re_q       <= 1'b0;
      ram_rd_addr_q  <= '0;
      re_last_q      <= 1'b0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      ram_re_q       <= ram_re_d;
      ram_rd_addr_q  <= ram_rd_addr_d;
      re_last_q      <= re_last_d;
      pending_q      <= ram_re_q;
      pending_last_q <= re_last_q;
    end
  end

  assign ram_re      = ram_re_q;
  assign ram_rd_addr = ram_rd_addr_q;

  stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pending_q),
    .push_data_i (ram_rd_data),
    .push_last_i (pending_last_q),
    .pop_i       (fire),
    .count_o     (fifo_count),
    .head_data_o (out_data),
    .head_last_o (head_last)
  );

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench: 1-cycle-latency RAM model, expected-word scoreboard, directed and random bursts.
module tb_dpram_stream_reader;

  localparam int BUF = 4;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy, done, ram_re, out_valid, out_last;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data, out_data;

  dpram_stream_reader #(.ADDRESS_DEPTH(16), .DATA_WIDTH(8), .ADDRESS_SIZE(4), .BUF_DEPTH(BUF)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_re(ram_re), .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
  initial ram_rd_data = 8'h00;
  always @(posedge clk) if (ram_re) ram_rd_data <= mem[ram_rd_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the burst a start should produce, and what was observed.
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  logic [3:0] exp_addr[$];
  logic [7:0] data_log[$];
  logic [3:0] addr_log[$];
  int         pop_cyc[$];
  bit         model_busy = 0, rst_seen = 0, stall_prev = 0;
  logic [7:0] prev_data;
  int         outstanding = 0, max_out = 0, done_count = 0, cyc = 0;
  bit         rand_ready = 0;

  always @(negedge clk) begin
    bit   accept, fin;
    int   n;
    cyc++;
    fin = 0;
    if (rst_seen) begin
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_ram_re", ram_re, 0);       chk("rst_rd_addr", ram_rd_addr, 0);
      chk("rst_out_valid", out_valid, 0); chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
    end
    if (ram_re) begin
      addr_log.push_back(ram_rd_addr);
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
      chk("buffer_bound", (outstanding <= BUF), 1);
      if (exp_addr.size() == 0) chk("unexpected_ram_re", ram_re, 0);
      else chk("ram_rd_addr", ram_rd_addr, exp_addr.pop_front());
    end
    chk("busy", busy, model_busy);
    if (out_valid) begin
      if (stall_prev) chk("stall_stable", out_data, prev_data);
      if (exp_data.size() == 0) chk("unexpected_valid", out_valid, 0);
      else begin
        chk("out_data", out_data, exp_data[0]);
        chk("out_last", out_last, exp_last[0]);
        chk("done", done, out_ready && exp_last[0]);
        if (out_ready) begin
          data_log.push_back(out_data);
          pop_cyc.push_back(cyc);
          outstanding--;
          fin = exp_last[0];
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
        end
      end
    end else begin
      chk("done_idle", done, 0);
      if (stall_prev) chk("valid_dropped_in_stall", out_valid, 1);
    end
    if (done) done_count++;
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    if (rst) begin
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
      model_busy = 0; outstanding = 0; stall_prev = 0; rst_seen = 1;
    end else begin
      rst_seen = 0;
      accept = start && !model_busy && (length != 0);
      if (fin) model_busy = 0;
      if (accept) begin
        n = (length > 16) ? 16 : int'(length);
        for (int i = 0; i < n; i++) begin
          exp_addr.push_back(4'(int'(base_addr) + i));
          exp_data.push_back(8'h10 + 8'((int'(base_addr) + i) % 16));
          exp_last.push_back(i == n - 1);
        end
        model_busy = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_logs();
    data_log.delete(); addr_log.delete(); pop_cyc.delete();
    done_count = 0; max_out = 0;
  endtask

  task automatic pulse_start(input logic [3:0] b, input logic [4:0] l);
    base_addr = b; length = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!busy && !out_valid && exp_data.size() == 0 && exp_addr.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_timeout", ok, 1);
  endtask

  task automatic chk_stream(input string name, input logic [7:0] first, input int n);
    chk({name, "_count"}, data_log.size(), n);
    for (int i = 0; i < n && i < data_log.size(); i++) chk(name, data_log[i], first + 8'(i));
  endtask

  initial begin
    int cnt;
    bit got;
    rst = 1; start = 0; base_addr = 0; length = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    step();

    // Basic burst with latency and throughput pinned by literals.
    clear_logs();
    base_addr = 2; length = 4; start = 1;
    cnt = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      start = 0;
      cnt++;
      if (cnt == 1) chk("ram_re_after_start", ram_re, 1);
      if (out_valid) got = 1;
    end
    chk("first_valid_latency", cnt, 3);
    wait_idle();
    chk_stream("basic", 8'h12, 4);
    if (pop_cyc.size() == 4) chk("basic_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
    chk("basic_done_count", done_count, 1);

    // Address wrap.
    clear_logs();
    pulse_start(4'd14, 5'd4);
    wait_idle();
    chk("wrap_addr_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_a0", addr_log[0], 14); chk("wrap_a1", addr_log[1], 15);
      chk("wrap_a2", addr_log[2], 0);  chk("wrap_a3", addr_log[3], 1);
    end
    if (data_log.size() == 4) begin
      chk("wrap_d0", data_log[0], 8'h1E); chk("wrap_d1", data_log[1], 8'h1F);
      chk("wrap_d2", data_log[2], 8'h10); chk("wrap_d3", data_log[3], 8'h11);
    end

    // Back-pressure: consumer stalls for cycles 3-7 after start.
    clear_logs();
    base_addr = 0; length = 8; start = 1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 0;
      out_ready = (c < 3 || c > 7);
    end
    wait_idle();
    chk_stream("backpressure", 8'h10, 8);
    chk("backpressure_max_outstanding", max_out, BUF);
    chk("backpressure_done_count", done_count, 1);

    // Zero length is a no-op; oversize length clamps to the RAM depth.
    clear_logs();
    pulse_start(4'd3, 5'd0);
    repeat (8) step();
    chk("len0_reads", addr_log.size(), 0);
    chk("len0_words", data_log.size(), 0);
    chk("len0_done", done_count, 0);
    clear_logs();
    pulse_start(4'd0, 5'd20);
    wait_idle();
    chk("len20_reads", addr_log.size(), 16);
    chk_stream("len20", 8'h10, 16);

    // Start while busy is ignored.
    clear_logs();
    pulse_start(4'd3, 5'd4);
    step();
    pulse_start(4'd9, 5'd3);
    wait_idle();
    chk_stream("busy_start", 8'h13, 4);
    chk("busy_start_done_count", done_count, 1);

    // Reset mid-burst, then a fresh burst.
    clear_logs();
    pulse_start(4'd0, 5'd8);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) got = 1;
      else step();
    end
    chk("reset_burst_valid_seen", got, 1);
    step(); step();
    rst = 1;
    step();
    rst = 0;
    repeat (4) step();
    chk("reset_no_done", done_count, 0);
    clear_logs();
    pulse_start(4'd5, 5'd2);
    wait_idle();
    chk_stream("after_reset", 8'h15, 2);

    // Random bursts with random back-pressure, stray starts and occasional resets.
    rand_ready = 1;
    for (int k = 0; k < 40; k++) begin
      pulse_start(4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) step();
        pulse_start(4'($urandom_range(0, 15)), 5'($urandom_range(1, 20)));
      end
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 10)) step();
        rst = 1;
        step();
        rst = 0;
      end
      wait_idle();
    end
    rand_ready = 0;
    out_ready = 1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "global timeout");
  end

endmodule
